// File: rtl/can_cfg_pkg.sv
// Shared register indices, FSM state type and reset constants for the CAN configuration register file.
package can_cfg_pkg;

  localparam int unsigned NUM_REGS = 15;

  localparam logic [4:0] REG_MODE       = 5'd0;
  localparam logic [4:0] REG_BIT_TIMING = 5'd1;
  localparam logic [4:0] REG_INT_EN     = 5'd2;
  localparam logic [4:0] REG_INT_STATUS = 5'd3;
  localparam logic [4:0] REG_STATUS     = 5'd4;
  localparam logic [4:0] REG_TX_ID      = 5'd5;
  localparam logic [4:0] REG_TX_DLC     = 5'd6;
  localparam logic [4:0] REG_TX_DATA0   = 5'd7;
  localparam logic [4:0] REG_TX_DATA1   = 5'd8;
  localparam logic [4:0] REG_TX_CMD     = 5'd9;
  localparam logic [4:0] REG_RX_ID      = 5'd10;
  localparam logic [4:0] REG_RX_DLC     = 5'd11;
  localparam logic [4:0] REG_RX_DATA0   = 5'd12;
  localparam logic [4:0] REG_RX_DATA1   = 5'd13;
  localparam logic [4:0] REG_ERR_CNT    = 5'd14;

  localparam logic [31:0] MODE_RST_VAL = 32'h0000_0001;
  localparam logic [31:0] BT_RST_VAL   = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } cfg_state_t;

  function automatic logic reg_is_ro(input logic [4:0] idx);
    case (idx)
      REG_STATUS, REG_RX_ID, REG_RX_DLC, REG_RX_DATA0, REG_RX_DATA1, REG_ERR_CNT: reg_is_ro = 1'b1;
      default: reg_is_ro = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/can_cfg_sel_decode.sv
// Combinational decode of the one-hot register select into an index plus legality flags.
module can_cfg_sel_decode
  import can_cfg_pkg::*;
#(
  parameter int NUM_SEL = 31
) (
  input  logic [NUM_SEL-1:0] sel,
  output logic [4:0]         idx,
  output logic               onehot_ok,
  output logic               mapped,
  output logic               readable,
  output logic               writable
);

  logic [4:0] idx_s;

  // Priority encode; the result only matters when the select is one-hot.
  always_comb begin
    idx_s = 5'd0;
    for (int i = 0; i < NUM_SEL; i++) begin
      idx_s = sel[i] ? 5'(i) : idx_s;
    end
  end

  assign idx       = idx_s;
  assign onehot_ok = (sel != '0) && ((sel & (sel - NUM_SEL'(1))) == '0);
  assign mapped    = (idx_s < 5'(NUM_REGS));
  assign readable  = mapped && (idx_s != REG_TX_CMD);
  assign writable  = mapped && !reg_is_ro(idx_s);

endmodule

// File: rtl/can_cfg_regfile.sv
// CAN configuration/status register file behind the microcontroller interface.
// Define CAN_CFG_WPROT_EN to reject BIT_TIMING writes unless MODE[0] (reset_mode) is set.
module can_cfg_regfile
  import can_cfg_pkg::*;
#(
  parameter int          NUM_SEL  = 31,
  parameter logic [31:0] MODE_RST = MODE_RST_VAL,
  parameter logic [31:0] BT_RST   = BT_RST_VAL
) (
  input  logic               i_sys_clk,
  input  logic               i_reset_n,
  input  logic [31:0]        i_reg_w_bus,
  input  logic [NUM_SEL-1:0] i_rs_vector,
  input  logic               i_r_neg_w,
  output logic [31:0]        o_reg_r_data,
  output logic               o_reg_ack,
  output logic               o_reg_error,
  output logic [31:0]        o_mode,
  output logic [31:0]        o_bit_timing,
  output logic [31:0]        o_tx_id,
  output logic [31:0]        o_tx_dlc,
  output logic [31:0]        o_tx_data0,
  output logic [31:0]        o_tx_data1,
  output logic               o_tx_req,
  input  logic [31:0]        i_rx_id,
  input  logic [31:0]        i_rx_dlc,
  input  logic [31:0]        i_rx_data0,
  input  logic [31:0]        i_rx_data1,
  input  logic               i_rx_valid,
  input  logic [31:0]        i_status,
  input  logic [31:0]        i_err_cnt,
  input  logic [3:0]         i_evt,
  output logic               o_irq
);

  cfg_state_t         state_r;
  logic [NUM_SEL-1:0] sel_r;
  logic               rnw_r;
  logic [31:0]        wdata_r, resp_data_r, rdata_r;
  logic               resp_err_r, ack_r, err_r, tx_req_r, irq_r;
  logic [31:0]        mode_r, bt_r, tx_id_r, tx_d0_r, tx_d1_r;
  logic [31:0]        rx_id_r, rx_dlc_r, rx_d0_r, rx_d1_r;
  logic [3:0]         int_en_r, int_status_r, tx_dlc_r;

  logic [4:0]  idx_s;
  logic        onehot_s, mapped_s, readable_s, writable_s, wprot_s, illegal_s, wr_ok_s;
  logic [31:0] rd_mux_s;
  logic [3:0]  clr_s;

  can_cfg_sel_decode #(.NUM_SEL(NUM_SEL)) u_sel_decode (
    .sel       (sel_r),
    .idx       (idx_s),
    .onehot_ok (onehot_s),
    .mapped    (mapped_s),
    .readable  (readable_s),
    .writable  (writable_s)
  );

`ifdef CAN_CFG_WPROT_EN
  assign wprot_s = !rnw_r && (idx_s == REG_BIT_TIMING) && !mode_r[0];
`else
  assign wprot_s = 1'b0;
`endif

  assign illegal_s = !onehot_s || !mapped_s || (rnw_r && !readable_s) || (!rnw_r && !writable_s) || wprot_s;
  assign wr_ok_s   = (state_r == DECODE) && !rnw_r && !illegal_s;

  // Read data selection and W1C clear mask for the access held in sel_r.
  always_comb begin
    rd_mux_s = 32'h0;
    clr_s    = 4'h0;
    case (idx_s)
      REG_MODE:       rd_mux_s = mode_r;
      REG_BIT_TIMING: rd_mux_s = bt_r;
      REG_INT_EN:     rd_mux_s = {28'h0, int_en_r};
      REG_INT_STATUS: rd_mux_s = {28'h0, int_status_r};
      REG_STATUS:     rd_mux_s = i_status;
      REG_TX_ID:      rd_mux_s = tx_id_r;
      REG_TX_DLC:     rd_mux_s = {28'h0, tx_dlc_r};
      REG_TX_DATA0:   rd_mux_s = tx_d0_r;
      REG_TX_DATA1:   rd_mux_s = tx_d1_r;
      REG_RX_ID:      rd_mux_s = rx_id_r;
      REG_RX_DLC:     rd_mux_s = rx_dlc_r;
      REG_RX_DATA0:   rd_mux_s = rx_d0_r;
      REG_RX_DATA1:   rd_mux_s = rx_d1_r;
      REG_ERR_CNT:    rd_mux_s = {16'h0, i_err_cnt[15:0]};
      default:        rd_mux_s = 32'h0;
    endcase
    if (wr_ok_s && (idx_s == REG_INT_STATUS)) begin
      clr_s = wdata_r[3:0];
    end else begin
      clr_s = 4'h0;
    end
  end

  // Access FSM: capture, decode, one-cycle ack, then wait for the select to drop.
  always_ff @(posedge i_sys_clk) begin
    if (!i_reset_n) begin
      state_r     <= IDLE;
      sel_r       <= '0;
      rnw_r       <= 1'b0;
      wdata_r     <= 32'h0;
      resp_data_r <= 32'h0;
      resp_err_r  <= 1'b0;
      ack_r       <= 1'b0;
      rdata_r     <= 32'h0;
      err_r       <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_rs_vector != '0) begin
            sel_r   <= i_rs_vector;
            rnw_r   <= i_r_neg_w;
            wdata_r <= i_reg_w_bus;
            state_r <= DECODE;
          end
        end
        DECODE: begin
          resp_err_r  <= illegal_s;
          resp_data_r <= (illegal_s || !rnw_r) ? 32'h0 : rd_mux_s;
          state_r     <= RESP;
        end
        RESP: begin
          ack_r   <= 1'b1;
          rdata_r <= resp_data_r;
          err_r   <= resp_err_r;
          state_r <= RELEASE;
        end
        RELEASE: begin
          if (i_rs_vector == '0) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Register storage, RX capture, event latching and interrupt output.
  always_ff @(posedge i_sys_clk) begin
    if (!i_reset_n) begin
      mode_r       <= MODE_RST;
      bt_r         <= BT_RST;
      int_en_r     <= 4'h0;
      int_status_r <= 4'h0;
      tx_id_r      <= 32'h0;
      tx_dlc_r     <= 4'h0;
      tx_d0_r      <= 32'h0;
      tx_d1_r      <= 32'h0;
      rx_id_r      <= 32'h0;
      rx_dlc_r     <= 32'h0;
      rx_d0_r      <= 32'h0;
      rx_d1_r      <= 32'h0;
      tx_req_r     <= 1'b0;
      irq_r        <= 1'b0;
    end else begin
      tx_req_r     <= wr_ok_s && (idx_s == REG_TX_CMD) && wdata_r[0];
      irq_r        <= |(int_status_r & int_en_r);
      int_status_r <= (int_status_r & ~clr_s) | i_evt;
      if (i_rx_valid) begin
        rx_id_r  <= i_rx_id;
        rx_dlc_r <= i_rx_dlc;
        rx_d0_r  <= i_rx_data0;
        rx_d1_r  <= i_rx_data1;
      end
      if (wr_ok_s) begin
        case (idx_s)
          REG_MODE:       mode_r   <= wdata_r;
          REG_BIT_TIMING: bt_r     <= wdata_r;
          REG_INT_EN:     int_en_r <= wdata_r[3:0];
          REG_TX_ID:      tx_id_r  <= wdata_r;
          REG_TX_DLC:     tx_dlc_r <= wdata_r[3:0];
          REG_TX_DATA0:   tx_d0_r  <= wdata_r;
          REG_TX_DATA1:   tx_d1_r  <= wdata_r;
          default: begin
          end
        endcase
      end
    end
  end

  assign o_reg_r_data = rdata_r;
  assign o_reg_ack    = ack_r;
  assign o_reg_error  = err_r;
  assign o_mode       = mode_r;
  assign o_bit_timing = bt_r;
  assign o_tx_id      = tx_id_r;
  assign o_tx_dlc     = {28'h0, tx_dlc_r};
  assign o_tx_data0   = tx_d0_r;
  assign o_tx_data1   = tx_d1_r;
  assign o_tx_req     = tx_req_r;
  assign o_irq        = irq_r;

endmodule

// File: tb/tb_can_cfg_regfile.sv
// Scoreboard bench for can_cfg_regfile: directed scenarios plus randomized accesses against an array-based model.
module tb_can_cfg_regfile;

`ifdef CAN_CFG_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] wbus = 32'h0;
  logic [30:0] rs = 31'h0;
  logic        rnw = 1'b0;
  logic [31:0] rd_data, mode, bit_timing, tx_id, tx_dlc, tx_d0, tx_d1;
  logic        ack, rerr, tx_req, irq;
  logic [31:0] rx_id = 32'h0, rx_dlc = 32'h0, rx_d0 = 32'h0, rx_d1 = 32'h0;
  logic        rx_valid = 1'b0;
  logic [31:0] status_v = 32'h0, errcnt_v = 32'h0;
  logic [3:0]  evt = 4'h0;

  int total = 0;
  int bad = 0;
  int ack_count = 0;
  int txreq_count = 0;
  int exp_txreq = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  // Reference model: architectural register contents by index, plus the last captured RX frame.
  logic [31:0] m [0:14];
  logic [31:0] rx_m [0:3];

  always #5 clk = ~clk;

  can_cfg_regfile dut (
    .i_sys_clk(clk), .i_reset_n(reset_n), .i_reg_w_bus(wbus), .i_rs_vector(rs), .i_r_neg_w(rnw),
    .o_reg_r_data(rd_data), .o_reg_ack(ack), .o_reg_error(rerr),
    .o_mode(mode), .o_bit_timing(bit_timing), .o_tx_id(tx_id), .o_tx_dlc(tx_dlc),
    .o_tx_data0(tx_d0), .o_tx_data1(tx_d1), .o_tx_req(tx_req),
    .i_rx_id(rx_id), .i_rx_dlc(rx_dlc), .i_rx_data0(rx_d0), .i_rx_data1(rx_d1), .i_rx_valid(rx_valid),
    .i_status(status_v), .i_err_cnt(errcnt_v), .i_evt(evt), .o_irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m[i] = 32'h0;
    m[0] = 32'h0000_0001;
    for (int i = 0; i < 4; i++) rx_m[i] = 32'h0;
  endtask

  task automatic model_access(input logic [30:0] sel, input logic rd, input logic [31:0] wd,
                              output logic [31:0] ed, output logic ee);
    int n = 0;
    int idx = 0;
    bit ro;
    for (int i = 0; i < 31; i++) begin
      if (sel[i]) begin
        n++;
        idx = i;
      end
    end
    ro = (idx == 4) || (idx >= 10 && idx <= 14);
    ee = (n != 1) || (idx >= 15) || (rd && idx == 9) || (!rd && ro) ||
         (WPROT && !rd && idx == 1 && !m[0][0]);
    ed = 32'h0;
    if (!ee && rd) begin
      case (idx)
        4:       ed = status_v;
        10:      ed = rx_m[0];
        11:      ed = rx_m[1];
        12:      ed = rx_m[2];
        13:      ed = rx_m[3];
        14:      ed = {16'h0, errcnt_v[15:0]};
        default: ed = m[idx];
      endcase
    end
    if (!ee && !rd) begin
      case (idx)
        2, 6:    m[idx] = wd & 32'hF;
        3:       m[3] = m[3] & ~(wd & 32'hF);
        9:       if (wd[0]) exp_txreq++;
        default: m[idx] = wd;
      endcase
    end
  endtask

  // One full access; evt_dec is pulsed on i_evt in the DECODE cycle.
  task automatic access(input logic [30:0] sel, input logic rd, input logic [31:0] wd,
                        input int hold, input logic [3:0] evt_dec);
    logic [31:0] ed;
    logic ee;
    int acks0;
    int lat = 0;
    model_access(sel, rd, wd, ed, ee);
    m[3] = m[3] | {28'h0, evt_dec};
    exp_q.push_back({ee, ed});
    acks0 = ack_count;
    rs = sel;
    rnw = rd;
    wbus = wd;
    while (!ack && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      evt = (lat == 1) ? evt_dec : 4'h0;
    end
    evt = 4'h0;
    check("ack_latency", 32'(lat), 32'd3);
    for (int h = 0; h < hold; h++) begin
      rs = 31'($urandom) | 31'h1;
      rnw = ~rnw;
      wbus = $urandom;
      @(posedge clk); #1;
    end
    rs = 31'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ack_once", 32'(ack_count - acks0), 32'd1);
  endtask

  task automatic check_outputs();
    check("o_mode", mode, m[0]);
    check("o_bit_timing", bit_timing, m[1]);
    check("o_tx_id", tx_id, m[5]);
    check("o_tx_dlc", tx_dlc, m[6]);
    check("o_tx_data0", tx_d0, m[7]);
    check("o_tx_data1", tx_d1, m[8]);
    check("o_irq", {31'h0, irq}, {31'h0, |(m[2][3:0] & m[3][3:0])});
    check("tx_req_pulses", 32'(txreq_count), 32'(exp_txreq));
  endtask

  task automatic pulse_evt(input logic [3:0] e);
    evt = e;
    @(posedge clk); #1;
    evt = 4'h0;
    m[3] = m[3] | {28'h0, e};
    @(posedge clk); #1;
  endtask

  task automatic pulse_rx();
    rx_id = $urandom; rx_dlc = $urandom; rx_d0 = $urandom; rx_d1 = $urandom;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_m[0] = rx_id; rx_m[1] = rx_dlc; rx_m[2] = rx_d0; rx_m[3] = rx_d1;
  endtask

  // Monitor: every ack pops one expected response from the scoreboard.
  always @(negedge clk) begin
    if (tx_req) txreq_count++;
    if (ack) begin
      ack_count++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        check("r_data", rd_data, mon_e[31:0]);
        check("r_error", {31'h0, rerr}, {31'h0, mon_e[32]});
      end
    end
  end

  initial begin
    logic [30:0] sel;
    int acks0;
    int k;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_rdata", rd_data, 32'h0);
    check("rst_error", {31'h0, rerr}, 32'h0);
    check_outputs();

    // Read MODE after reset, select held for 5 cycles.
    access(31'h1, 1'b1, 32'h0, 5, 4'h0);
    // BIT_TIMING write/readback, then write-protection attempt.
    access(31'h2, 1'b0, 32'h0003_1C07, 0, 4'h0);
    access(31'h2, 1'b1, 32'h0, 0, 4'h0);
    access(31'h1, 1'b0, 32'h0, 0, 4'h0);
    access(31'h2, 1'b0, 32'h0000_0005, 0, 4'h0);
    access(31'h2, 1'b1, 32'h0, 0, 4'h0);
    access(31'h1, 1'b0, 32'h1, 0, 4'h0);
    check_outputs();
    // Illegal selects and RO write.
    access(31'h3, 1'b0, 32'hFFFF_FFFF, 0, 4'h0);
    access(31'h1 << 20, 1'b1, 32'h0, 0, 4'h0);
    access(31'h1 << 4, 1'b0, 32'hDEAD_BEEF, 0, 4'h0);
    check_outputs();
    // TX command and TX_CMD read.
    access(31'h1 << 9, 1'b0, 32'h1, 0, 4'h0);
    access(31'h1 << 9, 1'b1, 32'h0, 0, 4'h0);
    check_outputs();
    // Interrupts: enable, event, W1C racing an event, W1C alone.
    access(31'h1 << 2, 1'b0, 32'hF, 0, 4'h0);
    pulse_evt(4'b0010);
    check("irq_after_evt", {31'h0, irq}, 32'h1);
    access(31'h1 << 3, 1'b0, 32'h2, 0, 4'b0010);
    check_outputs();
    access(31'h1 << 3, 1'b0, 32'h2, 0, 4'h0);
    check_outputs();

    // Reset while the access sits in DECODE: no ack, defaults restored.
    access(31'h1 << 5, 1'b0, 32'h1234_5678, 0, 4'h0);
    acks0 = ack_count;
    rs = 31'h1; rnw = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1; rs = 31'h0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check("no_ack_on_reset", 32'(ack_count - acks0), 32'd0);
    check_outputs();
    access(31'h1, 1'b1, 32'h0, 0, 4'h0);

    // Randomized traffic.
    for (int it = 0; it < 120; it++) begin
      k = $urandom_range(0, 11);
      if (k == 0) begin
        pulse_rx();
      end else if (k == 1) begin
        pulse_evt(4'($urandom));
      end else if (k == 2) begin
        status_v = $urandom;
        errcnt_v = $urandom;
      end else begin
        k = $urandom_range(0, 9);
        if (k == 0) sel = 31'($urandom) | 31'h1;
        else sel = 31'h1 << $urandom_range(0, (k < 3) ? 30 : 14);
        access(sel, 1'($urandom), $urandom, $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        check_outputs();
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
